jtdsp16_pcu: RTL and testbench



---
 rtl/jtdsp16_pcu.sv | 189 ++++++++++++++++++
 tb/tb_jtdsp16_pcu.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtdsp16_pcu.sv
// Program control unit: pc sequencing, return stack, pt/pi/i registers, do-loop cache, irq entry.
// Define JTDSP16_PCU_STKERR_EN to get sticky stack overflow/underflow flags.
module jtdsp16_pcu #(
    parameter int AW   = 16,
    parameter int STKD = 4,
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          goto_ja,
    input  logic          call_ja,
    input  logic          ret,
    input  logic          iret,
    input  logic          goto_pt,
    input  logic          call_pt,
    input  logic          icall,
    input  logic          pc_halt,
    input  logic [11:0]   i_field,
    input  logic          irq_start,
    input  logic          load_en,
    input  logic [1:0]    load_sel,
    input  logic [AW-1:0] load_data,
    input  logic          pt_read,
    input  logic          istep,
    input  logic          do_start,
    input  logic [3:0]    do_len,
    input  logic [CW-1:0] do_count,
    output logic [AW-1:0] rom_addr,
    output logic [AW-1:0] pt_addr,
    output logic [AW-1:0] reg_dout,
    output logic          do_active,
    output logic          irq_in,
    output logic          stk_ovf,
    output logic          stk_unf
);

    localparam int DW = $clog2(STKD) + 1;
    localparam logic [AW-1:0] HI_MASK = ~AW'(12'hFFF);

    logic [AW-1:0] pc, pc_inc, pc_nxt, pi, pt, ja_tgt;
    logic [11:0]   ireg, pt_lo;
    logic [AW-1:0] stk [STKD];
    logic [DW-1:0] depth;
    logic [AW-1:0] do_head, do_exit;
    logic [3:0]    do_ofs, do_len_r;
    logic [CW-1:0] do_rem;
    logic          irq_pend;
    logic          flow, irq_take, loop_end, loop_irq, push, pop;
    logic          ld_pt, ld_pr, ld_pi, ld_i;

    assign pc_inc   = pc + AW'(1);
    assign ja_tgt   = (pc & HI_MASK) | AW'(i_field);
    assign pt_lo    = pt[11:0] + (istep ? ireg : 12'd1);
    assign flow     = ~do_active;
    assign irq_take = irq_start & ~irq_in;
    assign loop_end = do_active & (do_ofs == do_len_r - 4'd1) & (do_rem == '0);
    assign loop_irq = loop_end & (irq_pend | irq_take);
    assign do_exit  = do_head + AW'(do_len_r);

    assign push = flow & ~icall & (call_ja | (call_pt & ~goto_ja));
    assign pop  = flow & ret & ~(icall | goto_ja | call_ja | goto_pt | call_pt);

    assign ld_pt = load_en & (load_sel == 2'd0);
    assign ld_pr = load_en & (load_sel == 2'd1);
    assign ld_pi = load_en & (load_sel == 2'd2);
    assign ld_i  = load_en & (load_sel == 2'd3);

    // During a loop pc holds still; the exit address is restored from do_head.
    always_comb begin
        pc_nxt = pc;
        if (do_active) begin
            if (loop_end) pc_nxt = loop_irq ? AW'(1) : do_exit;
        end else if (icall)                          pc_nxt = AW'(2);
        else if (irq_take & (goto_ja | call_ja))     pc_nxt = AW'(1);
        else if (goto_ja | call_ja)                  pc_nxt = ja_tgt;
        else if (goto_pt | call_pt)                  pc_nxt = pt;
        else if (ret)                                pc_nxt = stk[0];
        else if (iret)                               pc_nxt = pi;
        else if (pc_halt)                            pc_nxt = pc;
        else                                         pc_nxt = pc_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= '0;
            pi     <= '0;
            pt     <= '0;
            ireg   <= '0;
            irq_in <= 1'b0;
        end else if (cen) begin
            pc <= pc_nxt;
            if (ld_pt)        pt <= load_data;
            else if (pt_read) pt <= (pt & HI_MASK) | AW'(pt_lo);
            if (ld_i) ireg <= load_data[11:0];
            if (ld_pi)                                      pi <= load_data;
            else if (loop_irq)                              pi <= do_exit;
            else if (~irq_in & ~do_active & ~irq_start)     pi <= pc;
            if (loop_irq)                                   irq_in <= 1'b1;
            else if (flow & irq_take)                       irq_in <= 1'b1;
            else if (flow & iret)                           irq_in <= 1'b0;
        end
    end

    // stk[0] is the top and doubles as pr; popping the last entry leaves it in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STKD; k++) stk[k] <= '0;
            depth <= '0;
        end else if (cen) begin
            if (push) begin
                for (int unsigned k = 1; k < STKD; k++) stk[k] <= stk[k-1];
                stk[0] <= pc_inc;
                if (depth != DW'(STKD)) depth <= depth + DW'(1);
            end else if (pop) begin
                if (depth > DW'(1))
                    for (int unsigned k = 0; k + 1 < STKD; k++) stk[k] <= stk[k+1];
                if (depth != '0) depth <= depth - DW'(1);
            end else if (ld_pr) begin
                stk[0] <= load_data;
                if (depth == '0) depth <= DW'(1);
            end
        end
    end

`ifdef JTDSP16_PCU_STKERR_EN
    logic ovf_q, unf_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (cen) begin
            if (push && depth == DW'(STKD)) ovf_q <= 1'b1;
            if (pop && depth == '0)         unf_q <= 1'b1;
        end
    end
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;
`else
    assign stk_ovf = 1'b0;
    assign stk_unf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            do_active <= 1'b0;
            do_head   <= '0;
            do_ofs    <= '0;
            do_len_r  <= 4'd1;
            do_rem    <= '0;
            irq_pend  <= 1'b0;
        end else if (cen) begin
            if (do_active) begin
                if (loop_end) begin
                    do_active <= 1'b0;
                    irq_pend  <= 1'b0;
                end else begin
                    if (irq_take) irq_pend <= 1'b1;
                    if (do_ofs == do_len_r - 4'd1) begin
                        do_ofs <= '0;
                        do_rem <= do_rem - CW'(1);
                    end else begin
                        do_ofs <= do_ofs + 4'd1;
                    end
                end
            end else if (do_start) begin
                do_active <= 1'b1;
                do_head   <= pc_inc;
                do_ofs    <= '0;
                do_len_r  <= (do_len == 4'd0) ? 4'd1 : do_len;
                do_rem    <= (do_count > CW'(1)) ? do_count - CW'(1) : '0;
            end
        end
    end

    assign rom_addr = do_active ? do_head + AW'(do_ofs) : pc;
    assign pt_addr  = pt;

    always_comb begin
        reg_dout = '0;
        case (load_sel)
            2'd0:    reg_dout = pt;
            2'd1:    reg_dout = stk[0];
            2'd2:    reg_dout = pi;
            default: reg_dout = AW'($signed(ireg));
        endcase
    end

endmodule

// File: tb/tb_jtdsp16_pcu.sv
// Directed bench for jtdsp16_pcu with a queue-based reference model checked every cycle.
module tb_jtdsp16_pcu;

    localparam int AW = 16;
`ifdef JTDSP16_PCU_STKERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, cen;
    logic          goto_ja, call_ja, ret, iret, goto_pt, call_pt, icall, pc_halt;
    logic [11:0]   i_field;
    logic          irq_start, load_en, pt_read, istep, do_start;
    logic [1:0]    load_sel;
    logic [AW-1:0] load_data;
    logic [3:0]    do_len;
    logic [7:0]    do_count;
    logic [AW-1:0] rom_addr, pt_addr, reg_dout;
    logic          do_active, irq_in, stk_ovf, stk_unf;

    jtdsp16_pcu #(.AW(16), .STKD(4), .CW(8)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .goto_ja(goto_ja), .call_ja(call_ja), .ret(ret), .iret(iret),
        .goto_pt(goto_pt), .call_pt(call_pt), .icall(icall), .pc_halt(pc_halt),
        .i_field(i_field), .irq_start(irq_start),
        .load_en(load_en), .load_sel(load_sel), .load_data(load_data),
        .pt_read(pt_read), .istep(istep),
        .do_start(do_start), .do_len(do_len), .do_count(do_count),
        .rom_addr(rom_addr), .pt_addr(pt_addr), .reg_dout(reg_dout),
        .do_active(do_active), .irq_in(irq_in), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [15:0] m_pc = '0, m_pi = '0, m_pt = '0, m_pr = '0, m_exit = '0;
    logic [11:0] m_i = '0;
    logic [15:0] m_stk[$];
    logic [15:0] m_fq[$];
    bit m_irq = 0, m_pend = 0, m_ovf = 0, m_unf = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic m_push(input logic [15:0] v);
        m_stk.push_front(v);
        if (m_stk.size() > 4) begin
            void'(m_stk.pop_back());
            m_ovf = 1;
        end
        m_pr = v;
    endtask

    task automatic model_step();
        logic [15:0] npc, npi, npt;
        logic [11:0] lo;
        bit act, take, sop;
        int n, len;
        if (rst) begin
            m_pc = '0; m_pi = '0; m_pt = '0; m_pr = '0; m_i = '0;
            m_stk.delete(); m_fq.delete();
            m_irq = 0; m_pend = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        if (!cen) return;
        act  = (m_fq.size() != 0);
        take = irq_start && !m_irq;
        sop  = 0;
        npc = m_pc; npi = m_pi; npt = m_pt;
        if (load_en && load_sel == 2'd0) npt = load_data;
        else if (pt_read) begin
            lo  = m_pt[11:0] + (istep ? m_i : 12'd1);
            npt = {m_pt[15:12], lo};
        end
        if (act) begin
            void'(m_fq.pop_front());
            if (m_fq.size() == 0) begin
                if (m_pend || take) begin npc = 16'd1; m_irq = 1; npi = m_exit; end
                else npc = m_exit;
                m_pend = 0;
            end else if (take) m_pend = 1;
        end else begin
            if (!m_irq && !irq_start) npi = m_pc;
            if (icall) npc = 16'd2;
            else if (goto_ja || call_ja) begin
                npc = take ? 16'd1 : {m_pc[15:12], i_field};
                if (call_ja) begin m_push(m_pc + 16'd1); sop = 1; end
            end else if (goto_pt || call_pt) begin
                npc = m_pt;
                if (call_pt) begin m_push(m_pc + 16'd1); sop = 1; end
            end else if (ret) begin
                sop = 1;
                if (m_stk.size() == 0) begin m_unf = 1; npc = m_pr; end
                else begin
                    npc = m_stk.pop_front();
                    if (m_stk.size() != 0) m_pr = m_stk[0];
                end
            end else if (iret) npc = m_pi;
            else if (!pc_halt) npc = m_pc + 16'd1;
            if (take) m_irq = 1;
            else if (iret) m_irq = 0;
            if (do_start) begin
                len = (do_len == 0) ? 1 : int'(do_len);
                n   = (do_count < 2) ? 1 : int'(do_count);
                for (int p = 0; p < n; p++)
                    for (int o = 0; o < len; o++) m_fq.push_back(m_pc + 16'd1 + 16'(o));
                m_exit = m_pc + 16'd1 + 16'(len);
            end
        end
        if (load_en && load_sel == 2'd1 && !sop) begin
            if (m_stk.size() == 0) m_stk.push_back(load_data);
            else m_stk[0] = load_data;
            m_pr = load_data;
        end
        if (load_en && load_sel == 2'd2) npi = load_data;
        if (load_en && load_sel == 2'd3) m_i = load_data[11:0];
        m_pc = npc; m_pi = npi; m_pt = npt;
    endtask

    task automatic check_all();
        logic [15:0] er, ed;
        er = (m_fq.size() != 0) ? m_fq[0] : m_pc;
        case (load_sel)
            2'd0:    ed = m_pt;
            2'd1:    ed = m_pr;
            2'd2:    ed = m_pi;
            default: ed = {{4{m_i[11]}}, m_i};
        endcase
        chk("rom_addr",  rom_addr,  er);
        chk("pt_addr",   pt_addr,   m_pt);
        chk("reg_dout",  reg_dout,  ed);
        chk("do_active", do_active, m_fq.size() != 0);
        chk("irq_in",    irq_in,    m_irq);
        chk("stk_ovf",   stk_ovf,   ERR & m_ovf);
        chk("stk_unf",   stk_unf,   ERR & m_unf);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        goto_ja = 0; call_ja = 0; ret = 0; iret = 0; goto_pt = 0; call_pt = 0;
        icall = 0; pc_halt = 0; irq_start = 0; load_en = 0; pt_read = 0; istep = 0;
        do_start = 0;
    endtask

    task automatic reset_dut();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    logic [15:0] ret_exp [5] = '{16'h0051, 16'h0041, 16'h0031, 16'h0021, 16'h0021};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle(); cen = 1; rst = 1; i_field = '0; load_sel = '0; load_data = '0;
        do_len = '0; do_count = '0;
        tick(); tick(); rst = 0;
        chk("pin_reset_rom", rom_addr, 16'h0000);

        // pc to 0x123 with one stacked entry, then reset clears it all
        call_ja = 1; i_field = 12'h123; tick(); idle();
        chk("pin_pc_123", rom_addr, 16'h0123);
        rst = 1; tick(); rst = 0;
        load_sel = 2'd1; #1;
        chk("pin_rst_rom", rom_addr, 16'h0000);
        chk("pin_rst_pr",  reg_dout, 16'h0000);
        chk("pin_rst_ovf", stk_ovf, 1'b0);
        chk("pin_rst_unf", stk_unf, 1'b0);
        ret = 1; tick(); idle();
        chk("pin_empty_ret", rom_addr, 16'h0000);
        chk("pin_empty_unf", stk_unf, ERR);

        // five nested calls into a four-deep stack, then five returns
        reset_dut();
        goto_ja = 1; i_field = 12'h010; tick(); idle();
        for (int k = 1; k <= 5; k++) begin
            call_ja = 1; i_field = 12'((k + 1) * 16); tick(); idle();
            chk("pin_call_tgt", rom_addr, 16'((k + 1) * 16));
        end
        chk("pin_ovf", stk_ovf, ERR);
        chk("pin_pr_top", reg_dout, 16'h0051);
        for (int k = 0; k < 5; k++) begin
            ret = 1; tick(); idle();
            chk("pin_ret_tgt", rom_addr, ret_exp[k]);
        end
        chk("pin_unf", stk_unf, ERR);

        // pt post-modify wraps within the low 12 bits
        reset_dut();
        load_en = 1; load_sel = 2'd0; load_data = 16'h3FFE; tick();
        load_sel = 2'd3; load_data = 16'h0003; tick(); idle();
        load_sel = 2'd0;
        pt_read = 1; istep = 1; tick();
        chk("pin_pt_1", pt_addr, 16'h3001);
        tick();
        chk("pin_pt_2", pt_addr, 16'h3004);
        istep = 0; tick(); idle();
        chk("pin_pt_inc", pt_addr, 16'h3005);
        load_en = 1; load_data = 16'h1234; pt_read = 1; tick(); idle();
        chk("pin_pt_loadwins", pt_addr, 16'h1234);
        load_en = 1; load_sel = 2'd3; load_data = 16'h0FFD; tick(); idle();
        chk("pin_i_sext", reg_dout, 16'hFFFD);

        // pc wrap, halt, icall, call_pt/ret, pr load into empty stack
        load_en = 1; load_sel = 2'd0; load_data = 16'hFFFF; tick(); idle();
        goto_pt = 1; tick(); idle();
        chk("pin_goto_pt", rom_addr, 16'hFFFF);
        tick();
        chk("pin_wrap", rom_addr, 16'h0000);
        pc_halt = 1; tick(); tick(); idle();
        icall = 1; tick(); idle();
        chk("pin_icall", rom_addr, 16'h0002);
        call_pt = 1; tick(); idle();
        ret = 1; tick(); idle();
        chk("pin_callpt_ret", rom_addr, 16'h0003);
        reset_dut();
        load_en = 1; load_sel = 2'd1; load_data = 16'h0ABC; tick(); idle();
        ret = 1; tick(); idle();
        chk("pin_pr_load_ret", rom_addr, 16'h0ABC);

        // do loop: three instructions, four passes
        reset_dut();
        goto_ja = 1; i_field = 12'h100; tick(); idle();
        do_start = 1; do_len = 4'd3; do_count = 8'd4; tick(); idle();
        chk("pin_loop_f0", rom_addr, 16'h0101);
        for (int k = 1; k < 12; k++) begin
            tick();
            chk("pin_loop_f", rom_addr, 16'h0101 + 16'(k % 3));
        end
        tick();
        chk("pin_loop_done", do_active, 1'b0);
        chk("pin_loop_exit", rom_addr, 16'h0104);
        // count 0 runs once; do_start inside a loop is ignored
        do_start = 1; do_len = 4'd2; do_count = 8'd0; tick(); idle();
        chk("pin_once_f0", rom_addr, 16'h0105);
        do_start = 1; do_len = 4'd5; do_count = 8'd9; tick(); idle();
        chk("pin_once_f1", rom_addr, 16'h0106);
        tick();
        chk("pin_once_exit", rom_addr, 16'h0107);

        // irq inside a loop is held until the loop ends
        reset_dut();
        goto_ja = 1; i_field = 12'h300; tick(); idle();
        do_start = 1; do_len = 4'd2; do_count = 8'd2; tick(); idle();
        irq_start = 1; goto_ja = 1; i_field = 12'h555; tick(); idle();
        chk("pin_irq_defer", irq_in, 1'b0);
        tick(); tick(); tick();
        load_sel = 2'd2; #1;
        chk("pin_irq_vec", rom_addr, 16'h0001);
        chk("pin_irq_in", irq_in, 1'b1);
        chk("pin_irq_pi", reg_dout, 16'h0303);
        tick();
        irq_start = 1; goto_ja = 1; i_field = 12'h0AA; tick(); idle();
        chk("pin_irq_ignored", rom_addr, 16'h00AA);
        iret = 1; tick(); idle();
        chk("pin_iret", rom_addr, 16'h0303);
        chk("pin_iret_clr", irq_in, 1'b0);
        tick();
        irq_start = 1; goto_ja = 1; i_field = 12'h040; tick(); idle();
        chk("pin_irq_direct", rom_addr, 16'h0001);
        tick();
        iret = 1; tick(); idle();

        // clock enable low freezes everything, reset still acts
        reset_dut();
        goto_ja = 1; i_field = 12'h303; tick(); idle();
        load_sel = 2'd1;
        cen = 0; call_ja = 1; i_field = 12'h777;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("pin_cen_pc", rom_addr, 16'h0303);
        end
        chk("pin_cen_pr", reg_dout, 16'h0000);
        chk("pin_cen_ovf", stk_ovf, 1'b0);
        idle(); rst = 1; tick(); rst = 0;
        chk("pin_cen_rst", rom_addr, 16'h0000);
        cen = 1; tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
